// File: rtl/sd_spi_pkg.sv
// Shared constants for the SPI-mode SD card responder: command indices,
// R1 bit positions, response lengths and FSM encoding.
package sd_spi_pkg;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD58  = 6'd58;
  localparam logic [5:0] CMD59  = 6'd59;

  localparam int R1_IDLE     = 0;
  localparam int R1_ILLEGAL  = 2;
  localparam int R1_CRC_ERR  = 3;

  localparam logic [5:0] RESP_LEN_R1   = 6'd8;
  localparam logic [5:0] RESP_LEN_LONG = 6'd40;

  typedef enum logic [2:0] {
    RX_HUNT = 3'd0,
    RX_CMD  = 3'd1,
    DECODE  = 3'd2,
    NCR     = 3'd3,
    TX      = 3'd4
  } state_e;

  function automatic logic [7:0] r1_byte(input logic crc_err, input logic illegal,
                                         input logic idle);
    logic [7:0] r;
    r = 8'h00;
    r[R1_CRC_ERR] = crc_err;
    r[R1_ILLEGAL] = illegal;
    r[R1_IDLE]    = idle;
    return r;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enable, MSB-first.
module sd_crc7 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic       fb_s;

  always_comb begin
    crc_d = crc_q;
    fb_s  = 1'b0;
    if (clr_i) begin
      crc_d = 7'h00;
    end else if (en_i) begin
      fb_s  = bit_i ^ crc_q[6];
      crc_d = {crc_q[5:0], 1'b0} ^ {3'b000, fb_s, 2'b00, fb_s};
    end else begin
      crc_d = crc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/spi_sd_responder.sv
// SPI-mode SD card target: receives 48-bit command frames, tracks the
// idle/init state and returns R1/R3/R7 after a fixed Ncr gap.
module spi_sd_responder
  import sd_spi_pkg::*;
#(
  parameter int          NCR_BYTES      = 1,
  parameter int          ACMD41_RETRIES = 2,
  parameter logic [31:0] OCR            = 32'hC0FF8000,
  parameter bit          REQUIRE_CMD55  = 1'b0
) (
  input  logic        spi_clk_i,
  input  logic        spi_rst_i,
  input  logic        SCK_SPI,
  input  logic        MOSI,
  input  logic        SS_n,
  output logic        MISO,
  output logic        cmd_valid_o,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  output logic        idle_o
);

  localparam logic [15:0] NCR_BITS   = 16'(NCR_BYTES * 8);
  localparam logic [7:0]  RETRY_INIT = 8'(ACMD41_RETRIES);

  logic sck_meta_q, sck_s_q, sck_hist_q;
  logic mosi_meta_q, mosi_s_q;
  logic ss_meta_q, ss_s_q;
  logic rise_s, fall_s;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [47:0] shift_q, shift_d;
  logic [39:0] resp_q, resp_d;
  logic [5:0]  len_q, len_d;
  logic        miso_q, miso_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic [31:0] cmd_arg_q, cmd_arg_d;
  logic        idle_q, idle_d;
  logic [7:0]  retry_q, retry_d;
  logic        app_cmd_q, app_cmd_d;
  logic        crc_en_q, crc_en_d;

  logic        crc_clr_s, crc_feed_s;
  logic [6:0]  crc_calc_s;
  logic [47:0] frame_s;
  logic [5:0]  idx_s;
  logic [31:0] arg_s;
  logic        crc_err_s, illegal_s, idle_next_s;
  logic [7:0]  r1_s;

  // Two-flop synchronizers; SCK gets one extra history stage for edge detect.
  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) begin
      sck_meta_q  <= 1'b0;
      sck_s_q     <= 1'b0;
      sck_hist_q  <= 1'b0;
      mosi_meta_q <= 1'b1;
      mosi_s_q    <= 1'b1;
      ss_meta_q   <= 1'b1;
      ss_s_q      <= 1'b1;
    end else begin
      sck_meta_q  <= SCK_SPI;
      sck_s_q     <= sck_meta_q;
      sck_hist_q  <= sck_s_q;
      mosi_meta_q <= MOSI;
      mosi_s_q    <= mosi_meta_q;
      ss_meta_q   <= SS_n;
      ss_s_q      <= ss_meta_q;
    end
  end

  assign rise_s  = sck_s_q & ~sck_hist_q;
  assign fall_s  = ~sck_s_q & sck_hist_q;
  assign frame_s = {shift_q[46:0], mosi_s_q};
  assign idx_s   = shift_q[45:40];
  assign arg_s   = shift_q[39:8];

  sd_crc7 u_crc7 (
    .clk   (spi_clk_i),
    .rst   (spi_rst_i),
    .clr_i (crc_clr_s),
    .en_i  (crc_feed_s),
    .bit_i (mosi_s_q),
    .crc_o (crc_calc_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    resp_d      = resp_q;
    len_d       = len_q;
    miso_d      = miso_q;
    cmd_valid_d = 1'b0;
    cmd_index_d = cmd_index_q;
    cmd_arg_d   = cmd_arg_q;
    idle_d      = idle_q;
    retry_d     = retry_q;
    app_cmd_d   = app_cmd_q;
    crc_en_d    = crc_en_q;
    crc_clr_s   = 1'b0;
    crc_feed_s  = 1'b0;
    illegal_s   = 1'b0;
    idle_next_s = idle_q;
    r1_s        = 8'h00;
    crc_err_s   = ((idx_s == CMD0) || (idx_s == CMD8) || crc_en_q) &&
                  (crc_calc_s != shift_q[7:1]);

    if (ss_s_q) begin
      state_d = RX_HUNT;
      cnt_d   = 16'd0;
      miso_d  = 1'b1;
    end else begin
      case (state_q)
        RX_HUNT: begin
          if (rise_s) begin
            shift_d = frame_s;
            if (!mosi_s_q) begin
              state_d   = RX_CMD;
              cnt_d     = 16'd1;
              crc_clr_s = 1'b1;
            end else begin
              cnt_d = 16'd0;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        RX_CMD: begin
          if (rise_s) begin
            shift_d    = frame_s;
            crc_feed_s = (cnt_q < 16'd40);
            cnt_d      = cnt_q + 16'd1;
            if (cnt_q == 16'd47) begin
              cnt_d = 16'd0;
              if (!frame_s[47] && frame_s[46] && frame_s[0]) begin
                state_d = DECODE;
              end else begin
                state_d = RX_HUNT;
              end
            end else begin
              state_d = RX_CMD;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        DECODE: begin
          cmd_index_d = idx_s;
          cmd_arg_d   = arg_s;
          cmd_valid_d = 1'b1;
          len_d       = RESP_LEN_R1;
          state_d     = NCR;
          cnt_d       = 16'd0;
          if (crc_err_s) begin
            r1_s   = r1_byte(1'b1, 1'b0, idle_q);
            resp_d = {r1_s, 32'h0000_0000};
          end else begin
            app_cmd_d = 1'b0;
            case (idx_s)
              CMD0: begin
                idle_next_s = 1'b1;
                retry_d     = RETRY_INIT;
              end
              CMD8:  len_d = RESP_LEN_LONG;
              CMD55: app_cmd_d = 1'b1;
              ACMD41: begin
                if (REQUIRE_CMD55 && !app_cmd_q) begin
                  illegal_s = 1'b1;
                end else if (retry_q != 8'd0) begin
                  retry_d     = retry_q - 8'd1;
                  idle_next_s = 1'b1;
                end else begin
                  idle_next_s = 1'b0;
                end
              end
              CMD58: len_d = RESP_LEN_LONG;
              CMD59: crc_en_d = arg_s[0];
              default: illegal_s = 1'b1;
            endcase
            idle_d = idle_next_s;
            r1_s   = r1_byte(1'b0, illegal_s, idle_next_s);
            if (idx_s == CMD8) begin
              resp_d = {r1_s, 20'h00000, arg_s[11:0]};
            end else if (idx_s == CMD58) begin
              resp_d = {r1_s, OCR};
            end else begin
              resp_d = {r1_s, 32'h0000_0000};
            end
          end
        end
        NCR: begin
          if (rise_s && (cnt_q < NCR_BITS)) begin
            cnt_d = cnt_q + 16'd1;
          end else if (fall_s && (cnt_q == NCR_BITS)) begin
            miso_d  = resp_q[39];
            resp_d  = {resp_q[38:0], 1'b1};
            cnt_d   = 16'd1;
            state_d = TX;
          end else begin
            cnt_d = cnt_q;
          end
        end
        TX: begin
          // cnt_q counts bits already placed on MISO.
          if (fall_s && (cnt_q < {10'd0, len_q})) begin
            miso_d = resp_q[39];
            resp_d = {resp_q[38:0], 1'b1};
            cnt_d  = cnt_q + 16'd1;
          end else if (rise_s && (cnt_q == {10'd0, len_q})) begin
            miso_d  = 1'b1;
            cnt_d   = 16'd0;
            state_d = RX_HUNT;
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = RX_HUNT;
          cnt_d   = 16'd0;
          miso_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) begin
      state_q     <= RX_HUNT;
      cnt_q       <= 16'd0;
      shift_q     <= 48'h0;
      resp_q      <= 40'h0;
      len_q       <= RESP_LEN_R1;
      miso_q      <= 1'b1;
      cmd_valid_q <= 1'b0;
      cmd_index_q <= 6'd0;
      cmd_arg_q   <= 32'h0;
      idle_q      <= 1'b1;
      retry_q     <= RETRY_INIT;
      app_cmd_q   <= 1'b0;
      crc_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      resp_q      <= resp_d;
      len_q       <= len_d;
      miso_q      <= miso_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_index_q <= cmd_index_d;
      cmd_arg_q   <= cmd_arg_d;
      idle_q      <= idle_d;
      retry_q     <= retry_d;
      app_cmd_q   <= app_cmd_d;
      crc_en_q    <= crc_en_d;
    end
  end

  assign MISO        = miso_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_index_o = cmd_index_q;
  assign cmd_arg_o   = cmd_arg_q;
  assign idle_o      = idle_q;

endmodule
